fp_round_pipe: RTL and testbench
================================

# fp_round_pipe

Parametrised, pipelined rounding and packing stage for the floating-point add/sub datapath.
- Takes a normalised sum (exponent, mantissa, guard and sticky bits, operand signs) from the normaliser.
- Applies one of four IEEE rounding modes, selected per transaction.
- Resolves the result sign, including signed zero.
- Saturates exponent overflow to infinity or max-finite per mode.
- Emits the packed result with flags over a valid/ready handshake.
- Sits between the normaliser and the adder result port; replaces the fixed half-precision, RNE-only, combinational rounder.

## Interface
Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa width; packed result width is 1+EXP_W+MAN_W.
- CNT_W, 16, width of the saturating overflow event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts input this cycle.
- rnd_mode  in  2  0=RNE, 1=RTZ, 2=RUP (toward +inf), 3=RDN (toward -inf).
- zero_sum  in  1  exact sum is zero.
- norm_e  in  EXP_W+1  normalised exponent; MSB set means the exponent has already overflowed.
- norm_m  in  MAN_W  normalised mantissa, hidden bit excluded.
- g  in  1  first discarded bit.
- r  in  1  second discarded bit.
- s  in  1  sticky OR of the remaining discarded bits.
- sa  in  1  sign of A.
- sb  in  1  sign of B.
- ctrl  in  1  1 = subtract.
- max_ab  in  1  1 when |B| > |A|.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- z  out  1+EXP_W+MAN_W  packed result {sign, exp, man}.
- eof  out  1  exponent overflow occurred; result was saturated.
- inexact  out  1  at least one of g, r, s is set and zero_sum is 0.
- ovf_cnt  out  CNT_W  count of eof results accepted downstream; saturates at all-ones.
- ovf_clr  in  1  synchronous clear of ovf_cnt.

## Operation
Sign:
- Let sbe = sb^ctrl.
- Non-zero result: sign = (~max_ab & sa) | (sbe & (max_ab | sa)).
- Zero result: sign = (sa & sbe) | ((rnd_mode==3) & (sa ^ sbe)).

Round-up decision (RU), with sticky st = r|s:
- RNE: RU = g & (st | norm_m[0]).
- RTZ: RU = 0.
- RUP: RU = ~sign & (g|st).
- RDN: RU = sign & (g|st).

Arithmetic and overflow:
- m1 = norm_m + RU, computed at MAN_W+1 bits.
- The carry out of m1 adds 1 to the exponent. Exponent arithmetic is EXP_W+1 bits and never wraps.
- Overflow when the final exponent is ≥ 2^EXP_W−1, or when norm_e MSB is set.
- On overflow, eof=1 and the result is:
  - RNE: ±inf.
  - RTZ: ±max-finite.
  - RUP: +inf if positive, −max-finite if negative.
  - RDN: −inf if negative, +max-finite if positive.
- zero_sum=1 forces the exponent and mantissa to zero, with eof=0 and inexact=0. rnd_mode affects only the sign in this case.

Counter:
- ovf_cnt increments when out_valid & out_ready & eof.
- ovf_clr has priority over increment.

## Timing
Pipeline:
- Two register stages.
  - S1 registers the sign, RU, m1, the exponent-plus-carry, and the flags.
  - S2 registers the overflow resolution and the packed z.
- Latency is 2 cycles from input acceptance to out_valid when downstream is not stalled.
- Throughput is 1 result per cycle.

Stall and handshake:
- Global stall: adv = out_ready | ~out_valid, and in_ready = adv.
- When adv=0, both stages hold. Bubbles are not collapsed.
- While out_valid=1 and out_ready=0, z/eof/inexact stay stable.
- An input is accepted on in_valid & in_ready.

Reset:
- Reset clears both stage valids and ovf_cnt.
- During reset, out_valid=0, z=0, eof=0, inexact=0, ovf_cnt=0, and in_ready=1 one cycle after reset deasserts.
- Reset asserted mid-operation discards all in-flight transactions with no output.

Boundary conditions:
- An ovf_cnt increment at all-ones holds at all-ones.
- ovf_clr coinciding with an overflow acceptance leaves ovf_cnt=0.

## Structure
Shared package fp_pkg holds:
- rnd_mode_t enum (RNE/RTZ/RUP/RDN).
- EXP_W/MAN_W defaults.
- Functions for the inf and max-finite encodings.

One sub-module, fp_round_decide, is the combinational sign + RU + m1 logic of S1. It is reused by the multiplier rounder.

## Test plan
Defaults EXP_W=5, MAN_W=10 apply throughout.
- Mantissa carry: norm_e=15, norm_m=0x3FF, g=1, r=s=0, RNE, sa=sb=ctrl=0 -> z=0x4000, eof=0, inexact=1, two cycles after accept.
- Tie-to-even: norm_e=15, norm_m=0x002, g=1, r=s=0, RNE -> z=0x3C02; same with norm_m=0x003 -> z=0x3C04.
- Overflow modes: norm_e=30, norm_m=0x3FF, g=1, positive:
  - RNE -> z=0x7C00, eof=1.
  - RTZ -> z=0x7BFF, eof=0.
  - norm_e=31 with RTZ -> z=0x7BFF, eof=1.
  - negative with RUP -> z=0xFBFF, eof=1.
- Signed zero: zero_sum=1, sa=0, sb=1, ctrl=0:
  - RNE -> z=0x0000.
  - RDN -> z=0x8000.
  - sa=sb=1, ctrl=0 -> z=0x8000 in every mode.
- Backpressure: stream 6 back-to-back inputs with out_ready low for cycles 3–5 -> in_ready low for those cycles, no loss or duplication, outputs in order, z stable while stalled.
- Counter/reset: 3 overflow results accepted -> ovf_cnt=3; ovf_clr together with a 4th accepted overflow -> ovf_cnt=0; reset mid-stream -> out_valid=0 next cycle, no stale result after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding-mode encoding, default field
// widths and the special-value encodings used by the rounders.
package fp_pkg;

   typedef enum logic [1:0] {
      RNE = 2'd0,
      RTZ = 2'd1,
      RUP = 2'd2,
      RDN = 2'd3
   } rnd_mode_t;

   localparam int EXP_W_DEF = 5;
   localparam int MAN_W_DEF = 10;
   localparam int ENC_W     = 64;

   // Encodings are built in a wide vector; callers size-cast to their own width.
   function automatic logic [ENC_W-1:0] inf_enc(input logic sign, input int exp_w, input int man_w);
      logic [ENC_W-1:0] v;
      v = ((ENC_W'(1) << exp_w) - ENC_W'(1)) << man_w;
      v = v | (ENC_W'(sign) << (exp_w + man_w));
      return v;
   endfunction

   function automatic logic [ENC_W-1:0] max_finite_enc(input logic sign, input int exp_w, input int man_w);
      logic [ENC_W-1:0] v;
      v = ((ENC_W'(1) << exp_w) - ENC_W'(2)) << man_w;
      v = v | ((ENC_W'(1) << man_w) - ENC_W'(1));
      v = v | (ENC_W'(sign) << (exp_w + man_w));
      return v;
   endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational sign resolution, round-up decision and mantissa increment.
// Shared between the add/sub rounder and the multiplier rounder.
module fp_round_decide
   import fp_pkg::*;
#(
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic [1:0]       rnd_mode_i,
   input  logic             zero_sum_i,
   input  logic [MAN_W-1:0] norm_m_i,
   input  logic             g_i,
   input  logic             r_i,
   input  logic             s_i,
   input  logic             sa_i,
   input  logic             sb_i,
   input  logic             ctrl_i,
   input  logic             max_ab_i,
   output logic             sign_o,
   output logic [MAN_W:0]   m1_o
);

   rnd_mode_t mode;
   logic      sbe;
   logic      sticky;
   logic      signNz;
   logic      signZ;
   logic      roundUp;

   // Directed modes round away from zero only when the result sign points the
   // same way as the rounding direction; the non-zero sign drives that choice.
   always_comb begin
      mode    = rnd_mode_t'(rnd_mode_i);
      sbe     = sb_i ^ ctrl_i;
      sticky  = r_i | s_i;
      signNz  = (~max_ab_i & sa_i) | (sbe & (max_ab_i | sa_i));
      signZ   = (sa_i & sbe) | ((mode == RDN) & (sa_i ^ sbe));
      sign_o  = zero_sum_i ? signZ : signNz;
      roundUp = 1'b0;
      case (mode)
         RNE:     roundUp = g_i & (sticky | norm_m_i[0]);
         RTZ:     roundUp = 1'b0;
         RUP:     roundUp = ~signNz & (g_i | sticky);
         default: roundUp = signNz & (g_i | sticky);
      endcase
      m1_o = {1'b0, norm_m_i} + {{MAN_W{1'b0}}, roundUp};
   end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage rounding and packing stage for the add/sub datapath with a
// valid/ready handshake and a saturating overflow event counter.
module fp_round_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               rnd_mode,
   input  logic                     zero_sum,
   input  logic [EXP_W:0]           norm_e,
   input  logic [MAN_W-1:0]         norm_m,
   input  logic                     g,
   input  logic                     r,
   input  logic                     s,
   input  logic                     sa,
   input  logic                     sb,
   input  logic                     ctrl,
   input  logic                     max_ab,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     z,
   output logic                     eof,
   output logic                     inexact,
   output logic [CNT_W-1:0]         ovf_cnt,
   input  logic                     ovf_clr
);

   localparam int Z_W  = 1 + EXP_W + MAN_W;
   localparam int E1_W = EXP_W + 2;
   localparam logic [E1_W-1:0] EXP_SAT = E1_W'((1 << EXP_W) - 1);

   logic             adv;
   logic             signRd;
   logic [MAN_W:0]   m1Rd;

   logic             v1_q, v1_d;
   logic             sign1_q, sign1_d;
   logic [MAN_W-1:0] m1_q, m1_d;
   logic [E1_W-1:0]  e1_q, e1_d;
   logic             zero1_q, zero1_d;
   logic             inex1_q, inex1_d;
   rnd_mode_t        mode1_q, mode1_d;

   logic             v2_q, v2_d;
   logic [Z_W-1:0]   z_q, z_d;
   logic             eof_q, eof_d;
   logic             inex2_q, inex2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf;

   fp_round_decide #(
      .MAN_W (MAN_W)
   ) u_decide (
      .rnd_mode_i (rnd_mode),
      .zero_sum_i (zero_sum),
      .norm_m_i   (norm_m),
      .g_i        (g),
      .r_i        (r),
      .s_i        (s),
      .sa_i       (sa),
      .sb_i       (sb),
      .ctrl_i     (ctrl),
      .max_ab_i   (max_ab),
      .sign_o     (signRd),
      .m1_o       (m1Rd)
   );

   // One global advance: a stalled output freezes the whole pipe, bubbles included.
   assign adv       = out_ready | ~v2_q;
   assign in_ready  = adv;
   assign out_valid = v2_q;
   assign z         = z_q;
   assign eof       = eof_q;
   assign inexact   = inex2_q;
   assign ovf_cnt   = cnt_q;

   // The exponent is widened by one bit so a carry on an already-overflowed
   // exponent cannot wrap back into range.
   always_comb begin
      v1_d    = v1_q;
      sign1_d = sign1_q;
      m1_d    = m1_q;
      e1_d    = e1_q;
      zero1_d = zero1_q;
      inex1_d = inex1_q;
      mode1_d = mode1_q;
      if (adv) begin
         v1_d    = in_valid;
         sign1_d = signRd;
         m1_d    = m1Rd[MAN_W-1:0];
         e1_d    = {1'b0, norm_e} + E1_W'(m1Rd[MAN_W]);
         zero1_d = zero_sum;
         inex1_d = (g | r | s) & ~zero_sum;
         mode1_d = rnd_mode_t'(rnd_mode);
      end
   end

   always_comb begin
      ovf     = ~zero1_q & (e1_q >= EXP_SAT);
      v2_d    = v2_q;
      z_d     = z_q;
      eof_d   = eof_q;
      inex2_d = inex2_q;
      if (adv) begin
         v2_d    = v1_q;
         eof_d   = ovf;
         inex2_d = inex1_q;
         if (zero1_q) begin
            z_d = {sign1_q, {(Z_W-1){1'b0}}};
         end else if (ovf) begin
            case (mode1_q)
               RNE:     z_d = Z_W'(inf_enc(sign1_q, EXP_W, MAN_W));
               RTZ:     z_d = Z_W'(max_finite_enc(sign1_q, EXP_W, MAN_W));
               RUP:     z_d = sign1_q ? Z_W'(max_finite_enc(sign1_q, EXP_W, MAN_W))
                                      : Z_W'(inf_enc(sign1_q, EXP_W, MAN_W));
               default: z_d = sign1_q ? Z_W'(inf_enc(sign1_q, EXP_W, MAN_W))
                                      : Z_W'(max_finite_enc(sign1_q, EXP_W, MAN_W));
            endcase
         end else begin
            z_d = {sign1_q, e1_q[EXP_W-1:0], m1_q};
         end
      end
   end

   // Clear wins over a simultaneous overflow acceptance; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (ovf_clr) begin
         cnt_d = '0;
      end else if (v2_q & out_ready & eof_q & ~(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q    <= 1'b0;
         sign1_q <= 1'b0;
         m1_q    <= '0;
         e1_q    <= '0;
         zero1_q <= 1'b0;
         inex1_q <= 1'b0;
         mode1_q <= RNE;
         v2_q    <= 1'b0;
         z_q     <= '0;
         eof_q   <= 1'b0;
         inex2_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         sign1_q <= sign1_d;
         m1_q    <= m1_d;
         e1_q    <= e1_d;
         zero1_q <= zero1_d;
         inex1_q <= inex1_d;
         mode1_q <= mode1_d;
         v2_q    <= v2_d;
         z_q     <= z_d;
         eof_q   <= eof_d;
         inex2_q <= inex2_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe: hand-derived half-precision vectors,
// backpressure, overflow counter and reset behaviour.
module tb_fp_round_pipe;

   typedef struct packed {
      logic [1:0]  mode;
      logic        zs;
      logic [5:0]  ne;
      logic [9:0]  nm;
      logic [2:0]  grs;
      logic [3:0]  sgn;
      logic [15:0] ez;
      logic        eeof;
      logic        einx;
   } vec_t;

   localparam int NV = 18;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  rnd_mode;
   logic        zero_sum;
   logic [5:0]  norm_e;
   logic [9:0]  norm_m;
   logic        g, r, s, sa, sb, ctrl, max_ab;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] z;
   logic        eof;
   logic        inexact;
   logic [3:0]  ovf_cnt;
   logic        ovf_clr;

   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   vec_t vecs[NV];
   vec_t expQ[$];
   int   accQ[$];

   fp_round_pipe #(
      .EXP_W (5),
      .MAN_W (10),
      .CNT_W (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rnd_mode  (rnd_mode),
      .zero_sum  (zero_sum),
      .norm_e    (norm_e),
      .norm_m    (norm_m),
      .g         (g),
      .r         (r),
      .s         (s),
      .sa        (sa),
      .sb        (sb),
      .ctrl      (ctrl),
      .max_ab    (max_ab),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .eof       (eof),
      .inexact   (inexact),
      .ovf_cnt   (ovf_cnt),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input logic [1:0] mode, input logic zs, input logic [5:0] ne,
                               input logic [9:0] nm, input logic [2:0] grs, input logic [3:0] sgn,
                               input logic [15:0] ez, input logic eeof, input logic einx);
      vec_t v;
      v.mode = mode; v.zs = zs; v.ne = ne; v.nm = nm; v.grs = grs; v.sgn = sgn;
      v.ez = ez; v.eeof = eeof; v.einx = einx;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rnd_mode = v.mode;
      zero_sum = v.zs;
      norm_e   = v.ne;
      norm_m   = v.nm;
      {g, r, s} = v.grs;
      {sa, sb, ctrl, max_ab} = v.sgn;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks += 5;
      if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passes++;
      if (z !== 16'h0000) $display("[TB] FAIL reset_z got %h want 0000", z); else passes++;
      if (eof !== 1'b0) $display("[TB] FAIL reset_eof got %b want 0", eof); else passes++;
      if (inexact !== 1'b0) $display("[TB] FAIL reset_inexact got %b want 0", inexact); else passes++;
      if (ovf_cnt !== 4'd0) $display("[TB] FAIL reset_ovf_cnt got %0d want 0", ovf_cnt); else passes++;
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passes++;
   endtask

   task automatic test_rounding();
      int   idx;
      int   budget;
      int   lat;
      vec_t e;
      idx = 0;
      budget = 0;
      expQ.delete();
      accQ.delete();
      while ((idx < NV || expQ.size() != 0) && budget < 100) begin
         @(negedge clk);
         budget++;
         out_ready = 1'b1;
         #1;
         if (out_valid) begin
            checks++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL round_spurious got z=%h want no output", z);
            end else begin
               passes++;
               e = expQ.pop_front();
               lat = cyc - accQ.pop_front();
               checks += 4;
               if (z !== e.ez) $display("[TB] FAIL round_z got %h want %h", z, e.ez); else passes++;
               if (eof !== e.eeof) $display("[TB] FAIL round_eof z=%h got %b want %b", e.ez, eof, e.eeof); else passes++;
               if (inexact !== e.einx) $display("[TB] FAIL round_inexact z=%h got %b want %b", e.ez, inexact, e.einx); else passes++;
               if (lat !== 2) $display("[TB] FAIL round_latency got %0d want 2", lat); else passes++;
            end
         end
         if (idx < NV) begin
            applyStimulus(vecs[idx]);
            in_valid = 1'b1;
            if (in_ready) begin
               expQ.push_back(vecs[idx]);
               accQ.push_back(cyc);
               idx++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      if (budget >= 100) begin
         checks++;
         $display("[TB] FAIL round_timeout got %0d pending want 0", expQ.size());
      end
   endtask

   task automatic test_backpressure();
      int          idx;
      int          k;
      int          outs;
      logic [15:0] held;
      vec_t        e;
      idx = 0;
      k = 0;
      outs = 0;
      held = '0;
      expQ.delete();
      while ((idx < 6 || expQ.size() != 0) && k < 60) begin
         @(negedge clk);
         k++;
         out_ready = !(k >= 3 && k <= 5);
         #1;
         if (k >= 3 && k <= 5) begin
            checks += 2;
            if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready cycle %0d got %b want 0", k, in_ready); else passes++;
            if (out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid cycle %0d got %b want 1", k, out_valid); else passes++;
            if (k == 3) begin
               held = z;
            end else begin
               checks++;
               if (z !== held) $display("[TB] FAIL bp_stable cycle %0d got %h want %h", k, z, held); else passes++;
            end
         end
         if (out_valid && out_ready) begin
            outs++;
            checks++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL bp_duplicate got z=%h want no output", z);
            end else begin
               passes++;
               e = expQ.pop_front();
               checks += 2;
               if (z !== e.ez) $display("[TB] FAIL bp_z got %h want %h", z, e.ez); else passes++;
               if (eof !== e.eeof) $display("[TB] FAIL bp_eof got %b want %b", eof, e.eeof); else passes++;
            end
         end
         if (idx < 6) begin
            applyStimulus(vecs[12 + idx]);
            in_valid = 1'b1;
            if (in_ready) begin
               expQ.push_back(vecs[12 + idx]);
               idx++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (outs !== 6) $display("[TB] FAIL bp_count got %0d want 6", outs); else passes++;
   endtask

   task automatic test_counter();
      int seen;
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++;
      if (ovf_cnt !== 4'd0) $display("[TB] FAIL cnt_clear got %0d want 0", ovf_cnt); else passes++;
      applyStimulus(vecs[3]);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (ovf_cnt !== 4'd3) $display("[TB] FAIL cnt_three got %0d want 3", ovf_cnt); else passes++;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         @(negedge clk);
         #1;
         if (out_valid) begin
            seen = 1;
            ovf_clr = 1'b1;
         end
      end
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++;
      if (seen == 0) $display("[TB] FAIL cnt_clr_timeout got no output want one");
      else if (ovf_cnt !== 4'd0) $display("[TB] FAIL cnt_clr_priority got %0d want 0", ovf_cnt);
      else passes++;
      in_valid = 1'b1;
      @(negedge clk);
      applyStimulus(vecs[0]);
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (ovf_cnt !== 4'd1) $display("[TB] FAIL cnt_no_eof got %0d want 1", ovf_cnt); else passes++;
      applyStimulus(vecs[5]);
      in_valid = 1'b1;
      repeat (20) @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (ovf_cnt !== 4'hF) $display("[TB] FAIL cnt_saturate got %0d want 15", ovf_cnt); else passes++;
   endtask

   task automatic test_reset_midstream();
      int stale;
      out_ready = 1'b1;
      applyStimulus(vecs[3]);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checks += 3;
      if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid got %b want 0", out_valid); else passes++;
      if (z !== 16'h0000) $display("[TB] FAIL mid_z got %h want 0000", z); else passes++;
      if (ovf_cnt !== 4'd0) $display("[TB] FAIL mid_ovf_cnt got %0d want 0", ovf_cnt); else passes++;
      @(negedge clk);
      reset = 1'b0;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (out_valid) stale++;
      end
      checks += 2;
      if (stale !== 0) $display("[TB] FAIL mid_stale got %0d outputs want 0", stale); else passes++;
      if (in_ready !== 1'b1) $display("[TB] FAIL mid_in_ready got %b want 1", in_ready); else passes++;
   endtask

   initial begin
      vecs[0]  = mk(2'd0, 1'b0, 6'd15, 10'h3FF, 3'b100, 4'b0000, 16'h4000, 1'b0, 1'b1);
      vecs[1]  = mk(2'd0, 1'b0, 6'd15, 10'h002, 3'b100, 4'b0000, 16'h3C02, 1'b0, 1'b1);
      vecs[2]  = mk(2'd0, 1'b0, 6'd15, 10'h003, 3'b100, 4'b0000, 16'h3C04, 1'b0, 1'b1);
      vecs[3]  = mk(2'd0, 1'b0, 6'd30, 10'h3FF, 3'b100, 4'b0000, 16'h7C00, 1'b1, 1'b1);
      vecs[4]  = mk(2'd1, 1'b0, 6'd30, 10'h3FF, 3'b100, 4'b0000, 16'h7BFF, 1'b0, 1'b1);
      vecs[5]  = mk(2'd1, 1'b0, 6'd31, 10'h3FF, 3'b100, 4'b0000, 16'h7BFF, 1'b1, 1'b1);
      vecs[6]  = mk(2'd2, 1'b0, 6'd31, 10'h3FF, 3'b100, 4'b1100, 16'hFBFF, 1'b1, 1'b1);
      vecs[7]  = mk(2'd0, 1'b1, 6'd15, 10'h155, 3'b100, 4'b0100, 16'h0000, 1'b0, 1'b0);
      vecs[8]  = mk(2'd3, 1'b1, 6'd15, 10'h155, 3'b100, 4'b0100, 16'h8000, 1'b0, 1'b0);
      vecs[9]  = mk(2'd0, 1'b1, 6'd0,  10'h000, 3'b000, 4'b1100, 16'h8000, 1'b0, 1'b0);
      vecs[10] = mk(2'd1, 1'b1, 6'd0,  10'h000, 3'b000, 4'b1100, 16'h8000, 1'b0, 1'b0);
      vecs[11] = mk(2'd2, 1'b1, 6'd0,  10'h000, 3'b000, 4'b1100, 16'h8000, 1'b0, 1'b0);
      vecs[12] = mk(2'd3, 1'b1, 6'd0,  10'h000, 3'b000, 4'b1100, 16'h8000, 1'b0, 1'b0);
      vecs[13] = mk(2'd3, 1'b0, 6'd31, 10'h000, 3'b000, 4'b0000, 16'h7BFF, 1'b1, 1'b0);
      vecs[14] = mk(2'd2, 1'b0, 6'd10, 10'h100, 3'b010, 4'b0000, 16'h2901, 1'b0, 1'b1);
      vecs[15] = mk(2'd0, 1'b0, 6'd32, 10'h000, 3'b000, 4'b0000, 16'h7C00, 1'b1, 1'b0);
      vecs[16] = mk(2'd1, 1'b0, 6'd15, 10'h0AA, 3'b000, 4'b0011, 16'hBCAA, 1'b0, 1'b0);
      vecs[17] = mk(2'd3, 1'b0, 6'd1,  10'h3FF, 3'b001, 4'b1100, 16'h8800, 1'b0, 1'b1);

      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      ovf_clr = 1'b0;
      applyStimulus(vecs[0]);

      test_reset();
      test_rounding();
      test_backpressure();
      test_counter();
      test_reset_midstream();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
